uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO depth in bytes, a power of two, minimum 2.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning pointer width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning reset: asynchronous, active-low.
REQ-005 The block SHALL have port wr_data, input, 8 bits, meaning the byte to enqueue.
REQ-006 The block SHALL have port wr_en, input, 1 bit, meaning an enqueue request, sampled each clock.
REQ-007 The block SHALL have port flush, input, 1 bit, meaning a synchronous discard of all queued bytes.
REQ-008 The block SHALL have port full, output, 1 bit, meaning count equals DEPTH.
REQ-009 The block SHALL have port empty, output, 1 bit, meaning count equals 0.
REQ-010 The block SHALL have port count, output, ADDR_W+1 bits, meaning the number of queued bytes, excluding the byte in flight.
REQ-011 The block SHALL have port overflow, output, 1 bit, meaning a one-cycle pulse on each rejected write.
REQ-012 The block SHALL have port tx_data, output, 8 bits, meaning the byte presented to the transmitter.
REQ-013 The block SHALL have port tx_start, output, 1 bit, meaning a one-cycle launch pulse to the transmitter.
REQ-014 The block SHALL have port tx_busy, input, 1 bit, meaning the transmitter is shifting a frame.
REQ-015 The block SHALL have port tx_done, input, 1 bit, meaning the transmitter pulses this for one cycle at frame end.

Function
REQ-016 Storage SHALL be a circular buffer with rd_ptr and wr_ptr of ADDR_W bits, each wrapping from DEPTH-1 to 0.
REQ-017 A write SHALL be accepted when wr_en=1 and flush=0 and (full=0 or a pop occurs in the same cycle).
REQ-018 An accepted write SHALL store wr_data at wr_ptr and increment wr_ptr.
REQ-019 A write with wr_en=1 that is not accepted SHALL leave the FIFO unchanged and assert overflow in the next cycle.
REQ-020 Simultaneous accepted write and pop SHALL leave count unchanged.
REQ-021 The FSM SHALL have the states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-022 In IDLE with empty=0, tx_busy=0 and flush=0, the block SHALL pop: tx_data<=mem[rd_ptr], tx_start<=1, rd_ptr++, state<=WAIT_BUSY.
REQ-023 tx_start SHALL be registered and high for exactly one cycle per pop.
REQ-024 tx_data SHALL hold its value from a pop until the next pop.
REQ-025 In WAIT_BUSY: tx_busy=1 SHALL move the FSM to WAIT_DONE; tx_done=1 SHALL move it to IDLE.
REQ-026 In WAIT_DONE: tx_done=1, or tx_busy=0, SHALL move the FSM to IDLE.
REQ-027 Launch latency SHALL be: a write accepted at edge N into an empty FIFO with the FSM in IDLE produces tx_start=1 after edge N+1; there SHALL be no bypass path.
REQ-028 Back-to-back frames SHALL be launched no earlier than the edge after the FSM returns to IDLE.
REQ-029 flush=1 SHALL set rd_ptr=wr_ptr=0 and count=0 on the next edge, SHALL block writes and pops in that cycle, and SHALL NOT abort the in-flight frame or the FSM.
REQ-030 full, empty and count SHALL be derived from registered state and SHALL be valid in the same cycle as that state.

Reset
REQ-031 With rst=0, the block SHALL asynchronously clear the pointers and count and set the FSM to IDLE.
REQ-032 With rst=0, the block SHALL asynchronously drive tx_start=0, tx_data=8'h00, overflow=0, empty=1 and full=0.
REQ-033 Memory contents need not be reset.
REQ-034 Reset mid-frame SHALL discard all queued bytes; no tx_start SHALL be issued until after rst is released and a new write is accepted.
REQ-035 Reset SHALL be released synchronously to clk by the integrating logic.

Verification
REQ-036 Single byte: write 8'hA5 into an empty FIFO with tx_busy=0 -> tx_start pulses one cycle later with tx_data=8'hA5, and count returns to 0.
REQ-037 Burst: write 8'h01..8'h05 back-to-back while a transmitter model with 10-cycle frames is attached -> five tx_start pulses occur, in order, each after the previous tx_done.
REQ-038 Full and overflow: hold tx_busy=1 and write DEPTH+1 bytes -> full=1 after DEPTH writes, a single overflow pulse on the last write, and count=DEPTH.
REQ-039 Full with simultaneous pop: with the FIFO full, write while a pop occurs -> the write is accepted, overflow=0, and count stays at DEPTH.
REQ-040 Wrap-around: cycle 3*DEPTH bytes through the FIFO -> output order equals input order across pointer wrap.
REQ-041 Flush and reset: flush mid-frame -> count=0 and the in-flight frame completes; rst low mid-frame -> all outputs take their reset values immediately.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a launch/handshake FSM.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic              tx_done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic [ADDR_W-1:0] wr_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              pop;
  logic              accept;

  // Next-state, pop/accept decisions and next pointer/count values.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    accept     = 1'b0;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;

    case (state)
      IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          pop       = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tx_done) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (tx_done || !tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A full FIFO still takes a write when a byte leaves in the same cycle.
    accept = wr_en && !flush && (!full || pop);

    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (pop) begin
        rd_ptr_nxt = rd_ptr + ADDR_W'(1);
      end
      if (accept) begin
        wr_ptr_nxt = wr_ptr + ADDR_W'(1);
      end
      count_nxt = count + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // State, pointers, status flags and transmitter-facing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(DEPTH));
      empty    <= (count_nxt == '0);
      overflow <= wr_en && !accept;
      tx_start <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

  // Byte storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model plus a simple transmitter model.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            flush;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic            tx_done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: queued bytes and whether a launched frame is still owed an end.
  logic [7:0] q[$];
  bit         in_flight;
  bit         acked;
  logic       exp_start;
  logic       exp_ovf;
  logic [7:0] exp_data;
  bit         last_acc;

  // Transmitter model and observation logs.
  int         tx_left;
  int         frame_len;
  bit         rnd_frames;
  bit         hold_busy;
  bit         done_seen;
  int         done_cnt;
  logic [7:0] launched[$];
  logic [7:0] wlog[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_flight = 1'b0;
    acked     = 1'b0;
    exp_start = 1'b0;
    exp_ovf   = 1'b0;
    exp_data  = 8'h00;
  endtask

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_eval();
    bit pop;
    bit acc;
    pop = !in_flight && (q.size() > 0) && !tx_busy && !flush;
    acc = wr_en && !flush && ((q.size() < DEPTH) || pop);
    last_acc  = acc;
    exp_ovf   = wr_en && !acc;
    exp_start = pop;
    if (in_flight) begin
      if (!acked) begin
        if (tx_busy) acked = 1'b1;
        else if (tx_done) in_flight = 1'b0;
      end else if (tx_done || !tx_busy) begin
        in_flight = 1'b0;
      end
    end
    if (flush) q.delete();
    if (pop) begin
      exp_data  = q.pop_front();
      in_flight = 1'b1;
      acked     = 1'b0;
    end
    if (acc) q.push_back(wr_data);
  endtask

  task automatic check_outputs();
    chk("tx_start", 32'(tx_start), 32'(exp_start));
    chk("tx_data",  32'(tx_data),  32'(exp_data));
    chk("count",    32'(count),    32'(q.size()));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  // Transmitter: busy for a frame after each launch, then a one-cycle done.
  task automatic tx_update();
    if (tx_start === 1'b1) begin
      if (launched.size() > 0) chk("start_after_done", 32'(done_seen), 32'd1);
      done_seen = 1'b0;
      launched.push_back(tx_data);
    end
    if (hold_busy) begin
      tx_busy = 1'b1;
      tx_done = 1'b0;
      return;
    end
    tx_done = 1'b0;
    if (tx_start === 1'b1) begin
      tx_left = rnd_frames ? int'($urandom_range(1, 4)) : frame_len;
      tx_busy = 1'b1;
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) begin
        tx_busy   = 1'b0;
        tx_done   = 1'b1;
        done_seen = 1'b1;
        done_cnt++;
      end
    end else begin
      tx_busy = 1'b0;
    end
  endtask

  // One clock: apply inputs at the falling edge, predict, cross the rising edge, check.
  task automatic cyc(input logic w, input logic [7:0] d, input logic f);
    wr_en   = w;
    wr_data = d;
    flush   = f;
    model_eval();
    @(negedge clk);
    check_outputs();
    tx_update();
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while ((q.size() != 0 || in_flight || tx_busy || tx_done) && k < max_cyc) begin
      cyc(1'b0, 8'h00, 1'b0);
      k++;
    end
    chk("drain_idle", 32'(q.size() == 0 && !in_flight && !tx_busy && !tx_done), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_count"},    32'(count),    32'd0);
  endtask

  initial begin
    int n0;
    int d0;
    logic       w;
    logic       f;
    logic [7:0] d;
    int         guard;

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    tx_busy = 1'b0; tx_done = 1'b0;
    tx_left = 0; frame_len = 10; rnd_frames = 1'b0; hold_busy = 1'b0;
    done_seen = 1'b1; done_cnt = 0;
    model_reset();

    // Power-on reset asserted asynchronously before any clock edge.
    #1 rst = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    rst = 1'b1;

    // Single byte: start appears one edge after the accepting edge.
    cyc(1'b1, 8'hA5, 1'b0);
    chk("single_count_after_write", 32'(count), 32'd1);
    chk("single_no_bypass", 32'(tx_start), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("single_start", 32'(tx_start), 32'd1);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_count_zero", 32'(count), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("single_start_one_cycle", 32'(tx_start), 32'd0);
    drain(100);

    // Burst of five bytes through 10-cycle frames.
    launched.delete();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0);
    drain(300);
    chk("burst_launches", 32'(launched.size()), 32'd5);
    for (int i = 0; i < 5 && i < launched.size(); i++)
      chk("burst_order", 32'(launched[i]), 32'(i + 1));

    // Fill with the transmitter held busy, then one extra write.
    hold_busy = 1'b1;
    tx_busy   = 1'b1;
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom), 1'b0);
    chk("full_after_depth", 32'(full), 32'd1);
    chk("no_ovf_at_depth", 32'(overflow), 32'd0);
    cyc(1'b1, 8'hEE, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("count_depth", 32'(count), 32'(DEPTH));
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_single_pulse", 32'(overflow), 32'd0);

    // Full FIFO: write in the same cycle as a pop is accepted.
    hold_busy = 1'b0;
    tx_busy   = 1'b0;
    tx_left   = 0;
    frame_len = 3;
    cyc(1'b1, 8'h77, 1'b0);
    chk("fp_start", 32'(tx_start), 32'd1);
    chk("fp_no_ovf", 32'(overflow), 32'd0);
    chk("fp_count", 32'(count), 32'(DEPTH));
    drain(1000);

    // Wrap-around: 3*DEPTH accepted bytes with random gaps and frame lengths.
    launched.delete();
    wlog.delete();
    rnd_frames = 1'b1;
    guard = 0;
    while (wlog.size() < 3 * DEPTH && guard < 3000) begin
      w = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      cyc(w, d, 1'b0);
      if (last_acc) wlog.push_back(d);
      guard++;
    end
    drain(1000);
    chk("wrap_launches", 32'(launched.size()), 32'(wlog.size()));
    for (int i = 0; i < wlog.size() && i < launched.size(); i++)
      chk("wrap_order", 32'(launched[i]), 32'(wlog[i]));
    rnd_frames = 1'b0;

    // Flush while a frame is in flight.
    frame_len = 10;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    n0 = launched.size();
    d0 = done_cnt;
    cyc(1'b0, 8'h00, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    drain(100);
    chk("flush_frame_completes", 32'(done_cnt - d0), 32'd1);
    chk("flush_no_new_launch", 32'(launched.size()), 32'(n0));

    // Reset while a frame is in flight and bytes are queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC3 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    n0 = launched.size();
    wr_en = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_values("midrst");
    model_reset();
    @(negedge clk);
    tx_update();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("rst_no_launch", 32'(launched.size()), 32'(n0));
    drain(100);
    cyc(1'b1, 8'h5A, 1'b0);
    drain(100);
    chk("rst_relaunch_count", 32'(launched.size()), 32'(n0 + 1));
    if (launched.size() > 0) chk("rst_relaunch_data", 32'(launched[$]), 32'h5A);

    // Random traffic with occasional flushes.
    rnd_frames = 1'b1;
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 19) == 0);
      w = f ? 1'b0 : 1'($urandom_range(0, 1));
      cyc(w, 8'($urandom), f);
    end
    drain(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
